// File: rtl/led_blink_arbiter.sv
// Shares the LED pair between NREQ blink requesters, running one toggle burst at a time.
// Optional macro LED_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority.
module led_blink_arbiter #(
   parameter int NREQ     = 2,
   parameter int CNTW     = 8,
   parameter int IDW      = 1,
   parameter int TICK_DIV = 50000000
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ*CNTW-1:0] CNT,
   output logic [NREQ-1:0]      GNT,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [IDW-1:0]       DONE_ID,
   output logic [1:0]           LED
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            r_state;
   logic [NREQ-1:0]   r_gnt;
   logic              r_busy;
   logic              r_done;
   logic [IDW-1:0]    r_doneId;
   logic [IDW-1:0]    r_owner;
   logic              r_ledState;
   logic [PW-1:0]     r_presc;
   logic [CNTW-1:0]   r_remaining;

   logic              w_found;
   logic [IDW-1:0]    w_win;
   logic [CNTW-1:0]   w_winCnt;

`ifdef LED_ARB_RR_EN
   logic [IDW-1:0]    r_ptr;

   // Search begins just after the last served requester so each waiting one gets a turn.
   always_comb begin
      w_found  = 1'b0;
      w_win    = '0;
      w_winCnt = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && REQ[(int'(r_ptr) + k) % NREQ]) begin
            w_found  = 1'b1;
            w_win    = IDW'((int'(r_ptr) + k) % NREQ);
            w_winCnt = CNT[((int'(r_ptr) + k) % NREQ) * CNTW +: CNTW];
         end
      end
   end
`else
   // Downward scan so the lowest set index is the last assignment and wins.
   always_comb begin
      w_found  = 1'b0;
      w_win    = '0;
      w_winCnt = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (REQ[i]) begin
            w_found  = 1'b1;
            w_win    = IDW'(i);
            w_winCnt = CNT[i * CNTW +: CNTW];
         end
      end
   end
`endif

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_doneId    <= '0;
         r_owner     <= '0;
         r_ledState  <= 1'b0;
         r_presc     <= '0;
         r_remaining <= '0;
`ifdef LED_ARB_RR_EN
         r_ptr       <= IDW'(NREQ - 1);
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (w_found) begin
                  r_gnt       <= NREQ'(1) << w_win;
                  r_busy      <= 1'b1;
                  r_owner     <= w_win;
                  r_remaining <= w_winCnt;
                  r_presc     <= '0;
                  r_ledState  <= 1'b0;
                  r_state     <= RUN;
               end
            end
            RUN: begin
               // A zero-count grant holds GNT for its single cycle, then finishes without toggling.
               if (r_remaining == '0) begin
                  r_gnt    <= '0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_doneId <= r_owner;
                  r_state  <= FIN;
               end else if (r_presc == TICK_LAST) begin
                  r_presc     <= '0;
                  r_ledState  <= ~r_ledState;
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == CNTW'(1)) begin
                     r_gnt    <= '0;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_doneId <= r_owner;
                     r_state  <= FIN;
                  end
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            FIN: begin
               r_done  <= 1'b0;
`ifdef LED_ARB_RR_EN
               r_ptr   <= r_owner;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign GNT     = r_gnt;
   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign DONE_ID = r_doneId;
   assign LED     = {~r_ledState, r_ledState};

endmodule
